// File: rtl/fetch_unit_pkg.sv
// rtl/fetch_unit_pkg.sv - shared opcodes and instruction-queue entry layout for fetch_unit
package fetch_unit_pkg;

    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        pred_taken;
    } fq_entry_t;

endpackage

// File: rtl/fetch_predecode.sv
// rtl/fetch_predecode.sv - opcode check and J/B immediate extraction for early jumps
// FETCH_BTFN_PREDICT_EN: backward conditional branches also take the early-jump path.
module fetch_predecode
    import fetch_unit_pkg::*;
(
    input  logic [31:0] instr,
    output logic        early_jump,
    output logic [31:0] offset
);

    logic        is_jal;
    logic        is_back_branch;
    logic [31:0] j_imm;
    logic [31:0] b_imm;

    always_comb begin
        is_jal         = (instr[6:0] == OPC_JAL);
        is_back_branch = (instr[6:0] == OPC_BRANCH) && instr[31];
        j_imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
        b_imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
        // offset is only meaningful when early_jump is set
        offset = is_jal ? j_imm : b_imm;
`ifdef FETCH_BTFN_PREDICT_EN
        early_jump = is_jal || is_back_branch;
`else
        early_jump = is_jal && !is_back_branch || is_jal;
`endif
    end

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch: single-outstanding imem requests, pre-decode, queue to decode
// FETCH_BTFN_PREDICT_EN (in fetch_predecode) enables backward-branch early jumps.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] PC,
    input  logic        redirect,
    output logic        stall,
    output logic        jump_taken,
    output logic [31:0] PC_Jump,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        IF_valid,
    output logic [31:0] IF_instr,
    output logic [31:0] IF_pc,
    output logic        IF_pred_taken,
    input  logic        ID_ready
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    fq_entry_t      mem_q [DEPTH];
    fq_entry_t      mem_d [DEPTH];
    logic [PW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]  count_q, count_d;
    logic           outstanding_q, outstanding_d;
    logic           drop_q, drop_d;
    logic [31:0]    req_pc_q, req_pc_d;

    logic           pd_jump;
    logic [31:0]    pd_offset;
    logic           resp, live, early_jump, accept, enq, deq;
    fq_entry_t      head;

    fetch_predecode u_predecode (
        .instr      (imem_rdata),
        .early_jump (pd_jump),
        .offset     (pd_offset)
    );

    always_comb begin
        // responses with no request in flight (e.g. straddling reset) are ignored
        resp       = imem_rvalid && outstanding_q;
        live       = resp && !drop_q;
        early_jump = live && pd_jump;
        imem_req   = !redirect && (!outstanding_q || (resp && !early_jump))
                     && ((int'(count_q) + int'(outstanding_q)) < DEPTH);
        imem_addr  = PC;
        accept     = imem_req && imem_ready;
        stall      = !accept;
        jump_taken = early_jump && !redirect;
        PC_Jump    = jump_taken ? pd_offset : 32'd0;
        enq        = live && !redirect;
        deq        = (count_q != '0) && ID_ready && !redirect;
        head          = mem_q[rd_ptr_q];
        IF_valid      = (count_q != '0);
        IF_instr      = IF_valid ? head.instr : 32'd0;
        IF_pc         = IF_valid ? head.pc : 32'd0;
        IF_pred_taken = IF_valid && head.pred_taken;
    end

    always_comb begin
        mem_d         = mem_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        count_d       = count_q;
        req_pc_d      = accept ? PC : req_pc_q;
        outstanding_d = accept ? 1'b1 : (resp ? 1'b0 : outstanding_q);
        drop_d        = drop_q;
        if (redirect && outstanding_q && !imem_rvalid)
            drop_d = 1'b1;
        else if (resp && drop_q)
            drop_d = 1'b0;
        if (redirect) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (enq) begin
                mem_d[wr_ptr_q] = '{instr: imem_rdata, pc: req_pc_q, pred_taken: pd_jump};
                wr_ptr_d        = wr_ptr_q + 1'b1;
            end
            if (deq)
                rd_ptr_d = rd_ptr_q + 1'b1;
            count_d = count_q + CW'(enq) - CW'(deq);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            outstanding_q <= 1'b0;
            drop_q        <= 1'b0;
            req_pc_q      <= '0;
        end else begin
            mem_q         <= mem_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            outstanding_q <= outstanding_d;
            drop_q        <= drop_d;
            req_pc_q      <= req_pc_d;
        end
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage sitting directly downstream of the PC register and upstream of decode. Issues one instruction-memory request per cycle at the current PC and buffers returned instructions with their PCs in a small FIFO for decode. Pre-decodes each returned word to drive the PC's early-jump inputs (`jump_taken`, `PC_Jump`) and its `stall` input. Flushes on any redirect.

## Interface
- `DEPTH`, default 4: instruction-queue entries; power of two, ≥2.
- `clk`  in  1  clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `PC`  in  32  current PC from the PC register; the fetch address.
- `redirect`  in  1  PC_select OR EX_csr_branch_signal (PC is being overwritten this cycle).
- `stall`  out  1  to PC: hold PC this cycle.
- `jump_taken`  out  1  to PC: early jump this cycle.
- `PC_Jump`  out  32  to PC: sign-extended jump offset.
- `imem_req` / `imem_addr`  out  1 / 32  memory request; `imem_addr` = `PC`.
- `imem_ready`  in  1  memory accepts the request this cycle.
- `imem_rvalid` / `imem_rdata`  in  1 / 32  response, one per accepted request, in order.
- `IF_valid` / `IF_instr` / `IF_pc` / `IF_pred_taken`  out  1 / 32 / 32 / 1  head of queue to decode.
- `ID_ready`  in  1  decode consumes head when `IF_valid` is high.

## Operation
- Reset values: queue empty, `IF_valid`=0, `IF_instr`=`IF_pc`=0, `IF_pred_taken`=0, `jump_taken`=0, `PC_Jump`=0, no outstanding request, drop flag clear.
- At most one outstanding request. `outstanding` is set on accept (`imem_req && imem_ready`) and cleared on `imem_rvalid`. `req_pc` captures `PC` on accept.
- `imem_req` = !redirect && (!outstanding || (imem_rvalid && !early_jump)) && (count + outstanding < DEPTH). `imem_req` never depends on `imem_ready`.
- `stall` = !(imem_req && imem_ready). The PC advances by 4 only on an accepted request.
- Pre-decode applies on `imem_rvalid` with drop clear:
  - opcode 1101111 (JAL): early_jump=1, offset = J-immediate.
  - With the macro in Configuration: opcode 1100011 with imm[12]=1 (backward branch): early_jump=1, offset = B-immediate.
  - Otherwise early_jump=0.
- `jump_taken` = early_jump and `PC_Jump` = offset, both combinational in the response cycle. At that point the PC holds `req_pc`+4, so PC ← `req_pc` + offset. No request is issued in that cycle.
- Enqueue on `imem_rvalid` with drop clear: {`imem_rdata`, `req_pc`, early_jump}. Dequeue on `IF_valid && ID_ready`. Enqueue and dequeue in the same cycle leave `count` unchanged. Pointers wrap modulo `DEPTH`.
- On `redirect`:
  - Queue cleared next cycle; any same-cycle enqueue or dequeue is ignored.
  - `jump_taken` forced 0.
  - If a request is outstanding and its response has not arrived this cycle, the drop flag is set. The dropped response is discarded (no enqueue, no pre-decode, `jump_taken`=0) and clears drop.
  - A new request may issue in the cycle the dropped response returns.
- Reset asserted mid-operation returns all state to reset values immediately. An in-flight memory response after reset is ignored.

## Timing
- Request accepted in cycle t with 1-cycle memory: rdata in t+1, `IF_valid` in t+2. Sustained throughput is 1 instruction/cycle.
- Early jump costs one bubble: no request in the response cycle; the target request issues at t+2.
- Full queue: issue blocked while `count + outstanding` = `DEPTH`. The first issue follows the cycle after a dequeue.

## Configuration
- `FETCH_BTFN_PREDICT_EN` defined: backward conditional branches are predicted taken via the early-jump path, and `IF_pred_taken`=1 for them.
- Not defined: only JAL redirects early, and branches carry `IF_pred_taken`=0. The branch-resolution logic downstream uses `IF_pred_taken` to detect mispredicts.

## Structure
- Shared package: `OPC_JAL` (1101111), `OPC_BRANCH` (1100011), and the queue-entry layout {instr, pc, pred_taken}.
- One sub-module, `fetch_predecode`: combinational opcode check plus J/B immediate extraction → {early_jump, offset}.

## Test plan
- Straight line: `PC` 0,4,8 with `imem_ready`=1 and 1-cycle memory → `IF_pc` 0,4,8 on consecutive cycles from cycle 2; `stall`=0 throughout.
- JAL +0x100 at 0x10 (0x1000006F) → `jump_taken`=1 and `PC_Jump`=0x100 in the response cycle, `stall`=1; next request address 0x110.
- Decode stalled (`ID_ready`=0, `DEPTH`=4) → exactly 4 entries queued, `stall`=1. Set `ID_ready`=1 → entries drain in order and issue resumes.
- `redirect` while a request is outstanding → next cycle `IF_valid`=0; the returning response is not enqueued; a request at the new PC issues in that same cycle.
- BEQ with offset −8 (0xFE000CE3) → with `FETCH_BTFN_PREDICT_EN`: `jump_taken`=1, `PC_Jump`=0xFFFFFFF8, `IF_pred_taken`=1. Without it: `jump_taken`=0, `IF_pred_taken`=0.
- `rst` pulsed mid-stream with a full queue → `IF_valid`=0 and `jump_taken`=0 immediately; the first `imem_req` after release goes to `PC`.
